// File: rtl/async_fifo_pkg.sv
// Shared constants and pointer types for the async FIFO read and write sides.
package async_fifo_pkg;

    localparam int FIFO_AW = 3;

    typedef logic [FIFO_AW:0]   ptr_t;
    typedef logic [FIFO_AW-1:0] addr_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_p0;

    // stage 0 may go metastable; stage 1 gives it a full cycle to settle
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            q_p0 <= '0;
            q    <= '0;
        end else begin
            q_p0 <= d;
            q    <= q_p0;
        end
    end

endmodule

// File: rtl/rd_ptr_empty.sv
// Read-side pointer, empty flag, underflow pulse and pessimistic fill count for the async FIFO.
module rd_ptr_empty
    import async_fifo_pkg::*;
#(
    parameter int AW = FIFO_AW
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          rd_en,
    input  logic [AW:0]   wr_ptr_gray,
    output logic [AW:0]   rd_ptr_gray,
    output logic [AW-1:0] rd_addr,
    output logic          empty,
    output logic          underflow,
    output logic [AW:0]   rd_count
);

    localparam int PW = AW + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wq2_gray;
    logic [PW-1:0] wq2_bin;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;
    logic          rd_inc;

    sync_2ff #(
        .W(PW)
    ) u_wq2_sync (
        .clk   (clk),
        .resetb(resetb),
        .d     (wr_ptr_gray),
        .q     (wq2_gray)
    );

    always_comb begin
        rd_inc       = rd_en & ~empty;
        rd_bin_next  = rd_bin + {{AW{1'b0}}, rd_inc};
        rd_gray_next = bin2gray(rd_bin_next);
        wq2_bin      = gray2bin(wq2_gray);
    end

    assign rd_addr = rd_bin[AW-1:0];

    // Empty is evaluated against the post-read pointer so draining the last
    // entry raises it on the very next edge; the lap bit keeps it exact across wraps.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rd_bin      <= '0;
            rd_ptr_gray <= '0;
            empty       <= 1'b1;
            underflow   <= 1'b0;
            rd_count    <= '0;
        end else begin
            rd_bin      <= rd_bin_next;
            rd_ptr_gray <= rd_gray_next;
            empty       <= (rd_gray_next == wq2_gray);
            underflow   <= rd_en & empty;
            rd_count    <= wq2_bin - rd_bin_next;
        end
    end

endmodule

// File: tb/tb_rd_ptr_empty.sv
// Self-checking bench for rd_ptr_empty: directed steps plus randomized traffic against a queue-level model.
module tb_rd_ptr_empty;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int LAP   = 2 * DEPTH;

    logic          clk;
    logic          resetb;
    logic          rd_en;
    logic [AW:0]   wr_ptr_gray;
    logic [AW:0]   rd_ptr_gray;
    logic [AW-1:0] rd_addr;
    logic          empty;
    logic          underflow;
    logic [AW:0]   rd_count;

    int tests;
    int fails;

    // reference model: counts of items written / read, delay line for write visibility
    int w_cnt;
    int vis1, vis2;
    int m_rd;
    int m_empty, m_under, m_count;

    rd_ptr_empty #(.AW(AW)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .rd_en      (rd_en),
        .wr_ptr_gray(wr_ptr_gray),
        .rd_ptr_gray(rd_ptr_gray),
        .rd_addr    (rd_addr),
        .empty      (empty),
        .underflow  (underflow),
        .rd_count   (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW:0] to_gray(input int n);
        int v;
        v = n % LAP;
        return AW'(0) + (AW+1)'(v ^ (v >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rd    = 0;
        vis1    = 0;
        vis2    = 0;
        m_empty = 1;
        m_under = 0;
        m_count = 0;
    endtask

    task automatic check_model();
        chk("empty", {31'd0, empty}, m_empty);
        chk("underflow", {31'd0, underflow}, m_under);
        chk("rd_count", {28'd0, rd_count}, m_count);
        chk("rd_ptr_gray", {28'd0, rd_ptr_gray}, {28'd0, to_gray(m_rd)});
        chk("rd_addr", {29'd0, rd_addr}, m_rd % DEPTH);
    endtask

    // one clock: drive at negedge, update model at posedge, check just after
    task automatic step(input logic re, input int wn);
        int inc, rd_next;
        @(negedge clk);
        rd_en       = re;
        w_cnt       = wn;
        wr_ptr_gray = to_gray(wn);
        @(posedge clk);
        inc     = (re && m_empty == 0) ? 1 : 0;
        rd_next = (m_rd + inc) % LAP;
        m_under = (re && m_empty == 1) ? 1 : 0;
        m_empty = (rd_next == vis2) ? 1 : 0;
        m_count = (vis2 - rd_next + LAP) % LAP;
        vis2    = vis1;
        vis1    = wn % LAP;
        m_rd    = rd_next;
        #1;
        check_model();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_empty"}, {31'd0, empty}, 1);
        chk({tag, "_ptr"}, {28'd0, rd_ptr_gray}, 0);
        chk({tag, "_addr"}, {29'd0, rd_addr}, 0);
        chk({tag, "_count"}, {28'd0, rd_count}, 0);
        chk({tag, "_under"}, {31'd0, underflow}, 0);
    endtask

    initial begin
        int occ;
        tests = 0;
        fails = 0;
        w_cnt = 0;
        model_reset();

        // reset held with activity on the inputs
        resetb      = 1'b0;
        rd_en       = 1'b1;
        wr_ptr_gray = 4'b0011;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rd_en       = 1'b0;
        wr_ptr_gray = '0;
        resetb      = 1'b1;
        step(0, 0);
        step(0, 0);
        chk("post_reset_empty", {31'd0, empty}, 1);

        // single write: empty falls on the 3rd edge
        step(0, 1);
        chk("w1_edge1_empty", {31'd0, empty}, 1);
        step(0, 1);
        chk("w1_edge2_empty", {31'd0, empty}, 1);
        step(0, 1);
        chk("w1_edge3_empty", {31'd0, empty}, 0);
        chk("w1_count", {28'd0, rd_count}, 1);
        step(1, 1);
        chk("r1_addr", {29'd0, rd_addr}, 1);
        chk("r1_gray", {28'd0, rd_ptr_gray}, 1);
        chk("r1_empty", {31'd0, empty}, 1);

        // fill to eight entries, then drain with one extra read
        for (int i = 2; i <= 9; i++) step(0, i);
        repeat (3) step(0, 9);
        chk("fill_count", {28'd0, rd_count}, 8);
        for (int i = 0; i < 9; i++) step(1, 9);
        chk("drain_empty", {31'd0, empty}, 1);
        chk("drain_under", {31'd0, underflow}, 1);

        // underflow on consecutive cycles, pointer frozen
        for (int i = 0; i < 3; i++) begin
            step(1, 9);
            chk("under_pulse", {31'd0, underflow}, 1);
            chk("under_ptr", {28'd0, rd_ptr_gray}, {28'd0, to_gray(9)});
        end
        step(0, 9);
        chk("under_clear", {31'd0, underflow}, 0);

        // random traffic over several laps of the pointer space
        for (int i = 0; i < 400; i++) begin
            occ = (w_cnt - m_rd + 2 * LAP) % LAP;
            if (occ < DEPTH && $urandom_range(0, 2) != 0) step(1'($urandom_range(0, 1)), w_cnt + 1);
            else step(1'($urandom_range(0, 1)), w_cnt);
        end
        repeat (4) step(0, w_cnt);
        while (m_empty == 0) step(1, w_cnt);

        // last read coincides with a newly visible write
        step(0, w_cnt + 1);
        repeat (3) step(0, w_cnt);
        step(0, w_cnt + 1);
        step(0, w_cnt);
        step(1, w_cnt);
        chk("simul_empty", {31'd0, empty}, 0);
        chk("simul_count", {28'd0, rd_count}, 1);

        // asynchronous reset with five entries held
        for (int i = 0; i < 4; i++) step(0, w_cnt + 1);
        repeat (3) step(0, w_cnt);
        chk("pre_rst_count", {28'd0, rd_count}, 5);
        @(negedge clk);
        #2 resetb = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        w_cnt       = 0;
        wr_ptr_gray = '0;
        rd_en       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetb = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rd_ptr_empty.md
Name: rd_ptr_empty

Overview:
Read-side pointer and empty-flag logic for the async FIFO, and the counterpart of the write-side Gray pointer.
- Brings the write-domain Gray pointer into the read clock domain through a 2-flop synchronizer.
- Maintains the read pointer in binary and Gray form, drives the RAM read address, and generates a registered empty flag, an underflow pulse and a conservative fill count.
- Sits in the read clock domain, between the FIFO RAM read port and the consumer.

Parameters:
- AW, 3, FIFO address width; depth = 2**AW; pointer width PW = AW+1 (default 4 bits, matching the write-side Gray pointer).

Ports:
- clk  input  1  read-domain clock
- resetb  input  1  asynchronous, active-low reset for the read domain
- rd_en  input  1  consumer read request
- wr_ptr_gray  input  AW+1  write-side Gray pointer; asynchronous to clk
- rd_ptr_gray  output  AW+1  registered read Gray pointer, exported to the write-domain full logic
- rd_addr  output  AW  RAM read address
- empty  output  1  registered FIFO-empty flag
- underflow  output  1  one-cycle pulse on a read attempted while empty
- rd_count  output  AW+1  synchronized fill level, pessimistic (may overstate emptiness, never overstates data)

Behaviour:
- Reset (resetb=0, asynchronous assert, synchronous-to-clk release by system convention):
  - both sync flops = 0; rd_bin = 0; rd_ptr_gray = 0
  - empty = 1; underflow = 0; rd_count = 0
- Synchronizer:
  - wr_ptr_gray -> sync1 -> sync2 (wq2_gray), plain flops, no logic between stages.
  - wq2_gray is converted to binary (wq2_bin) combinationally.
- Read increment:
  - rd_inc = rd_en & ~empty
  - rd_bin_next = rd_bin + rd_inc, modulo 2**PW
  - rd_gray_next = bin2gray(rd_bin_next)
  - rd_bin and rd_ptr_gray are registered together every clk.
- rd_addr = rd_bin[AW-1:0]:
  - combinational from the register, so it always names the current head entry.
  - Read data is valid in the same cycle rd_inc is asserted (RAM read is combinational or pre-fetched).
- Empty:
  - empty <= (rd_gray_next == wq2_gray)
  - Reading the last entry asserts empty on the very next edge, so there is no read-past-empty window.
- Empty deassert latency:
  - after wr_ptr_gray changes (meeting setup), empty falls on the 3rd rising clk edge: sync1, sync2, then the empty register.
- Underflow:
  - underflow <= rd_en & empty; pointer unchanged; pulse lasts exactly one cycle per offending cycle.
- rd_count <= (wq2_bin - rd_bin_next) modulo 2**PW; range 0..2**AW.
- Wrap-around:
  - rd_bin wraps from 2**PW-1 to 0; with AW=3, Gray goes 1000 -> 0000.
  - The MSB difference carries the lap bit; the compare stays correct across laps.
- Simultaneous events:
  - Reading the last entry in the same cycle a new write becomes visible in wq2_gray: empty evaluates against the new wq2_gray, so it stays 0 and the pointer advances.
- Gray integrity:
  - rd_ptr_gray changes at most one bit per clk and comes straight from a flop, with no combinational glitch onto the CDC path.
- Reset mid-operation:
  - All state returns to reset values immediately on assertion.
  - In-flight synchronizer contents are discarded.
  - The write side must be reset in the same window; this block does not detect mismatch.

Decomposition:
- Package async_fifo_pkg holds:
  - FIFO_AW default constant
  - typedef ptr_t = logic [FIFO_AW:0]
  - typedef addr_t = logic [FIFO_AW-1:0]
- gray2bin and bin2gray (parameter W) are reused unchanged.
- One natural sub-module: sync_2ff (parameter W, clk, resetb, d, q), shared with the write-side full logic.

Test Plan:
1. Reset: hold resetb=0 with rd_en=1 and wr_ptr_gray=0011 -> empty=1, rd_ptr_gray=0000, rd_addr=0, rd_count=0, underflow=0; on release, empty=1 persists until sync completes.
2. Single write: drive wr_ptr_gray 0000->0001 -> empty falls on 3rd edge, rd_count=1; one rd_en cycle -> rd_addr 0->1, rd_ptr_gray=0001, empty=1 next edge.
3. Fill and drain with wrap (AW=3): step wr_ptr_gray through Gray codes to bin 8 (1100) -> rd_count=8; continuous rd_en for 9 cycles -> 8 reads on addr 0..7, then empty=1 and one underflow pulse; extend writes/reads past bin 15 -> rd_ptr_gray goes 1000->0000, no false empty/nonempty.
4. Underflow: rd_en=1 while empty for 3 cycles -> underflow high 3 cycles, rd_ptr_gray unchanged.
5. Simultaneous last-read/new-write: 1 entry present, wq2 advances in the same cycle rd_en reads it -> empty stays 0, rd_count=1.
6. Reset mid-stream: assert resetb with 5 entries held -> next sample shows empty=1, rd_ptr_gray=0, rd_count=0.
